// File: rtl/ov7670_stream_pkg.sv
// Shared types and constants for the synthetic OV7670 stream generator.
// Contents:
//   state_t    frame timing FSM states
//   pattern_t  test pattern select encoding
//   GRAY_BYTE  constant byte of the gray pattern
//   CHECK_SHIFT  coordinate bit that selects the checker square (8x8 squares)
//   cnt_width  counter width for a 0..n-1 range, never less than 1 bit
package ov7670_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_GRAY  = 2'b00,
        PAT_RAMP  = 2'b01,
        PAT_CHECK = 2'b10,
        PAT_COUNT = 2'b11
    } pattern_t;

    localparam logic [7:0]  GRAY_BYTE   = 8'h80;
    localparam int unsigned CHECK_SHIFT = 3;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// Camera-side bus of the synthetic OV7670 transmitter.
// Signals:
//   en          level, start/continue frames (into generator)
//   pattern     test pattern select (into generator)
//   vsync       frame sync, active high
//   href        high during active pixel bytes
//   dout        pixel byte, 8'h00 outside href
//   frame_done  1-cycle pulse on the last cycle of a frame
//   frame_sum   byte checksum of the last frame
// Modports: master = generator, slave = consumer (capture block or bench).
interface ov7670_stream_gen_if;

    logic        en;
    logic [1:0]  pattern;
    logic        vsync;
    logic        href;
    logic [7:0]  dout;
    logic        frame_done;
    logic [15:0] frame_sum;

    modport master (
        input  en,
        input  pattern,
        output vsync,
        output href,
        output dout,
        output frame_done,
        output frame_sum
    );

    modport slave (
        output en,
        output pattern,
        input  vsync,
        input  href,
        input  dout,
        input  frame_done,
        input  frame_sum
    );

endinterface

// File: rtl/ov7670_pattern_byte.sv
// Combinational test pattern byte generator.
// Ports:
//   i_pattern    selected pattern (latched per frame by the caller)
//   i_x, i_y     low 8 bits of pixel column / line
//   i_b          byte index within the pixel (0 = high byte, sent first)
//   i_frame_cnt  running frame counter
//   o_byte       pixel byte for this position
module ov7670_pattern_byte
    import ov7670_stream_pkg::*;
#(
    parameter int unsigned BW = 1
) (
    input  pattern_t        i_pattern,
    input  logic [7:0]      i_x,
    input  logic [7:0]      i_y,
    input  logic [BW-1:0]   i_b,
    input  logic [7:0]      i_frame_cnt,
    output logic [7:0]      o_byte
);

    always_comb begin
        o_byte = GRAY_BYTE;
        case (i_pattern)
            PAT_GRAY:  o_byte = GRAY_BYTE;
            PAT_RAMP:  o_byte = (i_b == '0) ? i_x : i_y;
            PAT_CHECK: o_byte = (i_x[CHECK_SHIFT] ^ i_y[CHECK_SHIFT]) ? 8'hFF : 8'h00;
            PAT_COUNT: o_byte = i_frame_cnt;
            default:   o_byte = GRAY_BYTE;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 transmitter: emits VSYNC/HREF/D8 with camera frame timing, clk25 is PCLK.
// Ports:
//   clk25  sole clock, also the emitted pixel clock
//   rst_n  asynchronous active-low reset, aborts any frame in progress
//   bus    ov7670_stream_gen_if.master (en, pattern in; vsync, href, dout, frame_done,
//          frame_sum out). All outputs are registered.
// Build option: define OV7670_STREAM_GEN_CHECKSUM_EN to build the per-frame byte checksum;
// otherwise frame_sum is tied to 16'h0000.
module ov7670_stream_gen
    import ov7670_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned BPP           = 2,
    parameter int unsigned H_BLANK       = 144,
    parameter int unsigned V_SYNC_LINES  = 3,
    parameter int unsigned V_BACK_LINES  = 17,
    parameter int unsigned V_FRONT_LINES = 10
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    ov7670_stream_gen_if.master  bus
);

    localparam int unsigned ACT_CYCLES   = H_ACTIVE * BPP;
    localparam int unsigned LINE_CYCLES  = ACT_CYCLES + H_BLANK;
    localparam int unsigned SYNC_CYCLES  = V_SYNC_LINES * LINE_CYCLES;
    localparam int unsigned BACK_CYCLES  = V_BACK_LINES * LINE_CYCLES;
    localparam int unsigned FRONT_CYCLES = V_FRONT_LINES * LINE_CYCLES;
    // Every vertical period spans at least one line, so it bounds ACTIVE/HBLANK too.
    localparam int unsigned MAX_SB       = (SYNC_CYCLES > BACK_CYCLES) ? SYNC_CYCLES
                                                                        : BACK_CYCLES;
    localparam int unsigned MAX_CYCLES   = (MAX_SB > FRONT_CYCLES) ? MAX_SB : FRONT_CYCLES;
    localparam int unsigned XW = cnt_width(H_ACTIVE);
    localparam int unsigned YW = cnt_width(V_ACTIVE);
    localparam int unsigned BW = cnt_width(BPP);
    localparam int unsigned CW = cnt_width(MAX_CYCLES);

    state_t          r_state, w_state_d;
    logic [CW-1:0]   r_cnt, w_cnt_d, w_period_m1;
    logic [XW-1:0]   r_x, w_x_d;
    logic [YW-1:0]   r_y, w_y_d;
    logic [BW-1:0]   r_b, w_b_d;
    pattern_t        r_pat;
    logic [7:0]      r_frame_cnt;
    logic            r_vsync, r_href, r_frame_done;
    logic [7:0]      r_dout;
    logic            w_last, w_frame_start, w_href_d, w_done_d;
    logic [7:0]      w_byte;

    always_comb begin
        w_period_m1 = '0;
        case (r_state)
            VSYNC:   w_period_m1 = CW'(SYNC_CYCLES - 1);
            VBACK:   w_period_m1 = CW'(BACK_CYCLES - 1);
            ACTIVE:  w_period_m1 = CW'(ACT_CYCLES - 1);
            HBLANK:  w_period_m1 = CW'(H_BLANK - 1);
            VFRONT:  w_period_m1 = CW'(FRONT_CYCLES - 1);
            default: w_period_m1 = '0;
        endcase
    end

    assign w_last = (r_cnt == w_period_m1);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + CW'(1);
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_b_d     = r_b;
        case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                if (bus.en) w_state_d = VSYNC;
            end
            VSYNC: begin
                if (w_last) begin
                    w_state_d = VBACK;
                    w_cnt_d   = '0;
                end
            end
            VBACK: begin
                if (w_last) begin
                    w_state_d = ACTIVE;
                    w_cnt_d   = '0;
                    w_x_d     = '0;
                    w_b_d     = '0;
                    w_y_d     = '0;
                end
            end
            ACTIVE: begin
                if (w_last) begin
                    w_state_d = HBLANK;
                    w_cnt_d   = '0;
                    w_x_d     = '0;
                    w_b_d     = '0;
                end else if (r_b == BW'(BPP - 1)) begin
                    w_b_d = '0;
                    w_x_d = r_x + XW'(1);
                end else begin
                    w_b_d = r_b + BW'(1);
                end
            end
            HBLANK: begin
                if (w_last) begin
                    w_cnt_d = '0;
                    if (r_y == YW'(V_ACTIVE - 1)) begin
                        w_state_d = VFRONT;
                        w_y_d     = '0;
                    end else begin
                        w_state_d = ACTIVE;
                        w_y_d     = r_y + YW'(1);
                    end
                end
            end
            VFRONT: begin
                if (w_last) begin
                    w_cnt_d   = '0;
                    w_state_d = bus.en ? VSYNC : IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign w_frame_start = (w_state_d == VSYNC) && (r_state != VSYNC);
    assign w_href_d      = (w_state_d == ACTIVE);
    assign w_done_d      = (w_state_d == VFRONT) && (w_cnt_d == CW'(FRONT_CYCLES - 1));

    // Byte is generated from next-cycle coordinates so it lands with href on the same edge.
    ov7670_pattern_byte #(
        .BW (BW)
    ) u_pattern (
        .i_pattern   (r_pat),
        .i_x         (8'(w_x_d)),
        .i_y         (8'(w_y_d)),
        .i_b         (w_b_d),
        .i_frame_cnt (r_frame_cnt),
        .o_byte      (w_byte)
    );

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_b          <= '0;
            r_pat        <= PAT_GRAY;
            r_frame_cnt  <= 8'h00;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_dout       <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_x          <= w_x_d;
            r_y          <= w_y_d;
            r_b          <= w_b_d;
            r_vsync      <= (w_state_d == VSYNC);
            r_href       <= w_href_d;
            r_dout       <= w_href_d ? w_byte : 8'h00;
            r_frame_done <= w_done_d;
            if (w_frame_start) r_pat <= pattern_t'(bus.pattern);
            if (r_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign bus.vsync      = r_vsync;
    assign bus.href       = r_href;
    assign bus.dout       = r_dout;
    assign bus.frame_done = r_frame_done;

`ifdef OV7670_STREAM_GEN_CHECKSUM_EN
    logic [15:0] r_acc, r_frame_sum;

    // The last active byte is summed well before the final VFRONT cycle, so r_acc is final
    // when frame_sum loads alongside frame_done.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= 16'h0000;
            r_frame_sum <= 16'h0000;
        end else begin
            if (w_frame_start) r_acc <= 16'h0000;
            else if (r_href)   r_acc <= r_acc + {8'h00, r_dout};
            if (w_done_d) r_frame_sum <= r_acc;
        end
    end

    assign bus.frame_sum = r_frame_sum;
`else
    assign bus.frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen: a small-parameter instance (60-cycle frames)
// for timing, pattern, enable, reset and checksum scenarios, plus a default-parameter
// instance for the 8x8 checker. Expected bytes are queued when a frame is started and
// popped whenever href is observed high.
module tb_ov7670_stream_gen;

    logic clk25 = 1'b0;
    logic rst_n;

    always #5 clk25 = ~clk25;

    ov7670_stream_gen_if s_if ();
    ov7670_stream_gen_if l_if ();

    ov7670_stream_gen #(
        .H_ACTIVE      (4),
        .V_ACTIVE      (3),
        .BPP           (2),
        .H_BLANK       (2),
        .V_SYNC_LINES  (1),
        .V_BACK_LINES  (1),
        .V_FRONT_LINES (1)
    ) dut_s (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    ov7670_stream_gen dut_l (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (l_if)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] model_byte(input logic [1:0] p, input int x, input int y,
                                              input int b, input logic [7:0] fc);
        case (p)
            2'b00:   return 8'h80;
            2'b01:   return (b == 0) ? x[7:0] : y[7:0];
            2'b10:   return (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default: return fc;
        endcase
    endfunction

    // {vsync, href, frame_done} for frame cycle tt (1..60) of the small instance.
    function automatic logic [2:0] exp_ctrl(input int tt);
        logic vs, hr, fd;
        vs = (tt <= 10);
        hr = (tt > 20) && (tt <= 50) && (((tt - 21) % 10) < 8);
        fd = (tt == 60);
        return {vs, hr, fd};
    endfunction

    task automatic push_frame(input logic [1:0] p, input logic [7:0] fc, input int h,
                              input int v, output logic [15:0] sum);
        logic [7:0] bt;
        sum = 16'h0000;
        for (int y = 0; y < v; y++)
            for (int x = 0; x < h; x++)
                for (int b = 0; b < 2; b++) begin
                    bt = model_byte(p, x, y, b, fc);
                    exp_q.push_back(bt);
                    sum = sum + {8'h00, bt};
                end
    endtask

    task automatic do_reset;
        s_if.en      = 1'b0;
        s_if.pattern = 2'b00;
        l_if.en      = 1'b0;
        l_if.pattern = 2'b00;
        exp_q.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk25);
        rst_n = 1'b1;
        @(negedge clk25);
    endtask

    task automatic wait_vsync_s(input int budget, output int cyc);
        int n;
        n   = 0;
        cyc = 0;
        while (cyc == 0 && n < budget) begin
            @(negedge clk25);
            n++;
            if (s_if.vsync === 1'b1) cyc = n;
        end
    endtask

    task automatic test_reset;
        s_if.en      = 1'b1;
        s_if.pattern = 2'b01;
        l_if.en      = 1'b1;
        l_if.pattern = 2'b10;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk25);
        checks++;
        if ({s_if.vsync, s_if.href, s_if.frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000", {s_if.vsync, s_if.href, s_if.frame_done});
        end
        checks++;
        if (s_if.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h want 00", s_if.dout);
        end
        checks++;
        if (s_if.frame_sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sum got %h want 0000", s_if.frame_sum);
        end
        checks++;
        if ({l_if.vsync, l_if.href, l_if.dout} !== 10'h000) begin
            errors++;
            $display("FAIL reset_large got %h want 000", {l_if.vsync, l_if.href, l_if.dout});
        end
        s_if.en = 1'b0;
        l_if.en = 1'b0;
        rst_n   = 1'b1;
        repeat (5) @(negedge clk25);
        checks++;
        if ({s_if.vsync, s_if.href, s_if.dout} !== 10'h000) begin
            errors++;
            $display("FAIL idle_hold got %h want 000", {s_if.vsync, s_if.href, s_if.dout});
        end
    endtask

    // Scenario: en=1, ramp pattern, full frame timing, then back-to-back VSYNC.
    task automatic test_ramp_timing;
        int cyc;
        logic [15:0] sum;
        logic [7:0] eb;
        do_reset();
        push_frame(2'b01, 8'h00, 4, 3, sum);
        s_if.pattern = 2'b01;
        s_if.en      = 1'b1;
        wait_vsync_s(5, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL ramp_start got %0d want 1", cyc);
        end
        for (int t = 1; t <= 60; t++) begin
            if (t > 1) @(negedge clk25);
            checks++;
            if ({s_if.vsync, s_if.href, s_if.frame_done} !== exp_ctrl(t)) begin
                errors++;
                $display("FAIL ramp_ctrl t=%0d got %b want %b", t,
                         {s_if.vsync, s_if.href, s_if.frame_done}, exp_ctrl(t));
            end
            checks++;
            if (s_if.href === 1'b1) begin
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (s_if.dout !== eb) begin
                    errors++;
                    $display("FAIL ramp_byte t=%0d got %h want %h", t, s_if.dout, eb);
                end
            end else if (s_if.dout !== 8'h00) begin
                errors++;
                $display("FAIL ramp_blank t=%0d got %h want 00", t, s_if.dout);
            end
        end
        @(negedge clk25);
        checks++;
        if (s_if.vsync !== 1'b1) begin
            errors++;
            $display("FAIL ramp_next_vsync got %b want 1", s_if.vsync);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ramp_leftover got %0d want 0", exp_q.size());
        end
        s_if.en = 1'b0;
    endtask

    // Scenario: count pattern over back-to-back frames; pattern change mid frame 1.
    task automatic test_count_frames;
        int cyc, dones;
        logic [15:0] sum;
        logic [7:0] eb;
        do_reset();
        push_frame(2'b11, 8'h00, 4, 3, sum);
        push_frame(2'b11, 8'h01, 4, 3, sum);
        push_frame(2'b00, 8'h02, 4, 3, sum);
        s_if.pattern = 2'b11;
        s_if.en      = 1'b1;
        dones        = 0;
        wait_vsync_s(5, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL count_start got %0d want 1", cyc);
        end
        for (int t = 1; t <= 180; t++) begin
            if (t > 1) @(negedge clk25);
            if (t == 90) s_if.pattern = 2'b00;
            if (s_if.frame_done === 1'b1) dones++;
            checks++;
            if ({s_if.vsync, s_if.href, s_if.frame_done} !== exp_ctrl(((t - 1) % 60) + 1)) begin
                errors++;
                $display("FAIL count_ctrl t=%0d got %b want %b", t,
                         {s_if.vsync, s_if.href, s_if.frame_done}, exp_ctrl(((t - 1) % 60) + 1));
            end
            if (s_if.href === 1'b1) begin
                checks++;
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (s_if.dout !== eb) begin
                    errors++;
                    $display("FAIL count_byte t=%0d got %h want %h", t, s_if.dout, eb);
                end
            end
        end
        checks++;
        if (dones != 3) begin
            errors++;
            $display("FAIL count_dones got %0d want 3", dones);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL count_leftover got %0d want 0", exp_q.size());
        end
        s_if.en = 1'b0;
    endtask

    // Scenario: en dropped during line 1; frame completes, then stays idle.
    task automatic test_en_drop;
        int cyc, dones;
        logic [15:0] sum;
        logic [7:0] eb;
        logic [2:0] ec;
        do_reset();
        push_frame(2'b01, 8'h00, 4, 3, sum);
        s_if.pattern = 2'b01;
        s_if.en      = 1'b1;
        dones        = 0;
        wait_vsync_s(5, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL drop_start got %0d want 1", cyc);
        end
        for (int t = 1; t <= 170; t++) begin
            if (t > 1) @(negedge clk25);
            if (t == 32) s_if.en = 1'b0;
            if (s_if.frame_done === 1'b1) dones++;
            ec = (t <= 60) ? exp_ctrl(t) : 3'b000;
            checks++;
            if ({s_if.vsync, s_if.href, s_if.frame_done} !== ec) begin
                errors++;
                $display("FAIL drop_ctrl t=%0d got %b want %b", t,
                         {s_if.vsync, s_if.href, s_if.frame_done}, ec);
            end
            if (s_if.href === 1'b1) begin
                checks++;
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (s_if.dout !== eb) begin
                    errors++;
                    $display("FAIL drop_byte t=%0d got %h want %h", t, s_if.dout, eb);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL drop_dones got %0d want 1", dones);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_leftover got %0d want 0", exp_q.size());
        end
    endtask

    // Scenario: asynchronous reset during ACTIVE, then a clean full frame.
    task automatic test_reset_mid;
        int cyc;
        logic [15:0] sum;
        logic [7:0] eb;
        do_reset();
        push_frame(2'b11, 8'h00, 4, 3, sum);
        s_if.pattern = 2'b11;
        s_if.en      = 1'b1;
        wait_vsync_s(5, cyc);
        for (int t = 2; t <= 24; t++) @(negedge clk25);
        checks++;
        if (s_if.href !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre_href got %b want 1", s_if.href);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_if.vsync, s_if.href, s_if.dout} !== 10'h000) begin
            errors++;
            $display("FAIL rmid_async got %h want 000", {s_if.vsync, s_if.href, s_if.dout});
        end
        exp_q.delete();
        push_frame(2'b11, 8'h00, 4, 3, sum);
        @(negedge clk25);
        rst_n = 1'b1;
        wait_vsync_s(5, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL rmid_restart got %0d want 1", cyc);
        end
        for (int t = 1; t <= 60; t++) begin
            if (t > 1) @(negedge clk25);
            checks++;
            if ({s_if.vsync, s_if.href, s_if.frame_done} !== exp_ctrl(t)) begin
                errors++;
                $display("FAIL rmid_ctrl t=%0d got %b want %b", t,
                         {s_if.vsync, s_if.href, s_if.frame_done}, exp_ctrl(t));
            end
            if (s_if.href === 1'b1) begin
                checks++;
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (s_if.dout !== eb) begin
                    errors++;
                    $display("FAIL rmid_byte t=%0d got %h want %h", t, s_if.dout, eb);
                end
            end
        end
        s_if.en = 1'b0;
    endtask

    // Scenario: frame checksum load/hold across two frames.
    task automatic test_checksum;
        int cyc;
        logic [15:0] sum0, sum1, want;
        logic [7:0] eb;
        do_reset();
        push_frame(2'b01, 8'h00, 4, 3, sum0);
        push_frame(2'b11, 8'h01, 4, 3, sum1);
`ifndef OV7670_STREAM_GEN_CHECKSUM_EN
        sum0 = 16'h0000;
        sum1 = 16'h0000;
`endif
        s_if.pattern = 2'b01;
        s_if.en      = 1'b1;
        wait_vsync_s(5, cyc);
        for (int t = 1; t <= 121; t++) begin
            if (t > 1) @(negedge clk25);
            if (t == 30) s_if.pattern = 2'b11;
            if (t == 100) s_if.en = 1'b0;
            if (s_if.href === 1'b1) begin
                checks++;
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (s_if.dout !== eb) begin
                    errors++;
                    $display("FAIL sum_byte t=%0d got %h want %h", t, s_if.dout, eb);
                end
            end
            if (t == 1 || t == 59 || t == 60 || t == 90 || t == 119 || t == 121) begin
                want = (t < 60) ? 16'h0000 : ((t < 120) ? sum0 : sum1);
                checks++;
                if (s_if.frame_sum !== want) begin
                    errors++;
                    $display("FAIL frame_sum t=%0d got %h want %h", t, s_if.frame_sum, want);
                end
            end
        end
    endtask

    // Scenario: default parameters, checker pattern over lines 0..8.
    task automatic test_checker_large;
        int n, vs_cycles, seen;
        logic [15:0] sum;
        logic [7:0] eb;
        do_reset();
        push_frame(2'b10, 8'h00, 640, 9, sum);
        l_if.pattern = 2'b10;
        l_if.en      = 1'b1;
        seen = 0;
        n    = 0;
        while (seen == 0 && n < 5) begin
            @(negedge clk25);
            n++;
            if (l_if.vsync === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL large_start got 0 want 1");
        end
        vs_cycles = (seen != 0) ? 1 : 0;
        while (seen != 0 && vs_cycles < 6000) begin
            @(negedge clk25);
            if (l_if.vsync === 1'b1) vs_cycles++;
            else seen = 0;
        end
        checks++;
        if (vs_cycles != 4272) begin
            errors++;
            $display("FAIL large_vsync_len got %0d want 4272", vs_cycles);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40000) begin
            @(negedge clk25);
            n++;
            if (l_if.href === 1'b1) begin
                checks++;
                eb = exp_q.pop_front();
                if (l_if.dout !== eb) begin
                    errors++;
                    $display("FAIL large_byte n=%0d left=%0d got %h want %h", n, exp_q.size(),
                             l_if.dout, eb);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL large_timeout got %0d want 0", exp_q.size());
        end
        l_if.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_timing();
        test_count_frames();
        test_en_drop();
        test_reset_mid();
        test_checksum();
        test_checker_large();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
